shared_adder_sequencer: RTL and testbench
=========================================

// Module: shared_adder_sequencer
// PURPOSE
//  Time-shares one 1-bit full-adder cell (two XOR half-adder stages + carry
//  flop) between two requesters, each submitting WIDTH-bit add operations.
//  A round-robin arbiter grants one request at a time. The FSM then streams
//  operands LSB-first through the cell and returns a WIDTH+1-bit sum over a
//  valid/ready response port. Sits between TT user-IO decode and the adder
//  datapath in the project top.
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range 2..16
// PORTS
//  clk        in   1        system clock; all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  req_valid  in   2        bit i: requester i has an operation pending
//  req_ready  out  2        bit i: requester i accepted this cycle (one-hot or 0)
//  req0_a     in   WIDTH    requester 0 operand A
//  req0_b     in   WIDTH    requester 0 operand B
//  req1_a     in   WIDTH    requester 1 operand A
//  req1_b     in   WIDTH    requester 1 operand B
//  rsp_valid  out  1        result available
//  rsp_ready  in   1        consumer takes result
//  rsp_sum    out  WIDTH+1  {carry_out, sum[WIDTH-1:0]}
//  rsp_id     out  1        index of requester that owns rsp_sum
//  busy       out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async, immediate):
//   - state=IDLE; rr_ptr=0; carry=0; bit counter=0; operand/sum regs=0.
//   - Outputs: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0.
//   - Reset mid-ADD or in DONE aborts the operation; no response is produced.
//  States: IDLE -> ADD -> DONE -> IDLE.
//  IDLE:
//   - Grant g = rr_ptr if req_valid[rr_ptr], else ~rr_ptr if that is valid.
//   - req_ready[g]=1 combinationally in this cycle; the other bit is 0.
//   - No valid request: req_ready=0; stay in IDLE.
//   - On the grant edge: capture g's a/b, carry=0, cnt=0, rsp_id=g,
//     rr_ptr=~g, go to ADD.
//  ADD (exactly WIDTH cycles):
//   - s = a[0]^b[0]^carry; carry <= (a[0]&b[0]) | (carry&(a[0]^b[0])).
//   - a and b shift right by 1; s shifts into sum MSB (sum shifts right).
//   - cnt increments each cycle; after cnt==WIDTH-1, go to DONE.
//   - rsp_sum <= {final carry, sum}.
//  DONE:
//   - rsp_valid=1; rsp_sum and rsp_id held stable until rsp_valid&&rsp_ready.
//   - On handshake: go to IDLE; rsp_valid=0 from the next cycle.
//  rsp_sum retains its last value in IDLE; only DONE qualifies it.
//  Handshake rules:
//   - req_ready=0 in ADD and DONE. Requests are never queued.
//   - Requester holds req_valid and operands stable until its req_ready.
//   - Dropping req_valid before grant is legal and has no effect.
//  Latency: grant in cycle T -> rsp_valid first high in cycle T+WIDTH+1.
//   Minimum issue interval is WIDTH+2 cycles (one IDLE cycle per op).
//  Arithmetic: unsigned; sum is exact; no saturation or overflow flag beyond
//   rsp_sum[WIDTH].
// TESTING (WIDTH=8)
//  1 req_valid=01, a=0x5A b=0x33 -> req_ready=01 same cycle; 9 cycles later
//    rsp_valid=1, rsp_sum=0x08D, rsp_id=0.
//  2 req1 only, a=0xFF b=0x01, rr_ptr=0 -> req1 granted at once;
//    rsp_sum=0x100, rsp_id=1.
//  3 req_valid=11 held, rsp_ready=1 -> grants alternate 0,1,0,1;
//    grant edges 10 cycles apart; each sum matches its id's operands.
//  4 rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_sum, rsp_id stable;
//    req_ready=00 throughout; IDLE one cycle after rsp_ready=1.
//  5 rst_n low on 4th ADD cycle -> all outputs 0 immediately; no rsp_valid
//    after release; first grant then goes to req0 if both valid.
//  6 a=0x00 b=0x00 and a=0xFF b=0xFF -> rsp_sum=0x000 and 0x1FE.

Source files
------------

// File: rtl/shared_adder_sequencer.sv
// shared_adder_sequencer: round-robin arbiter time-sharing one bit-serial full-adder
// cell between two requesters, returning a WIDTH+1-bit sum over valid/ready.
module shared_adder_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_sum,
  output logic             rsp_id,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a, b;
  logic [SW-1:0] sum;
  logic [CW-1:0] cnt;
  logic rr_ptr, carry, g, s, c_nx, last, take;
  always_comb begin
    g = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    take = state == IDLE && |req_valid;
    s = a[0] ^ b[0] ^ carry;
    c_nx = (a[0] & b[0]) | (carry & (a[0] ^ b[0]));
    last = cnt == CW'(WIDTH - 1);
    req_ready = take ? (g ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = state == DONE;
    busy = state != IDLE;
    state_nx = take ? ADD : (state == ADD && last) ? DONE : (rsp_valid && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // The final sum bit never enters sum: it goes straight into rsp_sum with the carry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      sum <= '0;
      carry <= 1'b0;
      cnt <= '0;
      rr_ptr <= 1'b0;
      rsp_id <= 1'b0;
      rsp_sum <= '0;
    end else if (take) begin
      a <= g ? req1_a : req0_a;
      b <= g ? req1_b : req0_b;
      carry <= 1'b0;
      cnt <= '0;
      rsp_id <= g;
      rr_ptr <= ~g;
    end else if (state == ADD) begin
      a <= a >> 1;
      b <= b >> 1;
      sum <= SW'({s, sum} >> 1);
      carry <= c_nx;
      cnt <= cnt + CW'(1);
      if (last) rsp_sum <= {c_nx, s, sum};
    end
endmodule

// File: tb/tb_shared_adder_sequencer.sv
// tb_shared_adder_sequencer: directed and random operations against an arithmetic
// and round-robin reference model.
module tb_shared_adder_sequencer;
  localparam int W = 8;
  logic clk = 1'b0, rst_n, rsp_ready, rsp_valid, rsp_id, busy;
  logic [1:0] req_valid, req_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W:0] rsp_sum, obs_sum;
  logic last_g, obs_id;
  int tests = 0, fails = 0, cyc = 0, gcyc = 0;

  shared_adder_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom());
  endfunction

  // Starts at a negedge in IDLE, finishes at the negedge of the following IDLE cycle.
  task automatic do_op(input logic [1:0] vld, input logic [W-1:0] a0, b0, a1, b1,
                       input int hold, input bit gap);
    int n;
    logic nxt, g;
    logic [W:0] es;
    req_valid = vld;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    if (vld == 2'b00) begin
      chk("idle_rdy", req_ready, 0);
      chk("idle_busy", busy, 0);
      @(negedge clk);
      return;
    end
    nxt = ~last_g;
    g = vld[nxt] ? nxt : ~nxt;
    chk("grant", req_ready, g ? 2 : 1);
    if (gap) chk("gap", cyc - gcyc, W + 2);
    gcyc = cyc;
    last_g = g;
    es = g ? {1'b0, a1} + {1'b0, b1} : {1'b0, a0} + {1'b0, b0};
    @(negedge clk);
    chk("add_rdy", req_ready, 0);
    chk("add_busy", busy, 1);
    chk("add_vld", rsp_valid, 0);
    req_valid = 2'b00;
    n = 1;
    while (!rsp_valid && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, W + 1);
    chk("sum", rsp_sum, es);
    chk("id", rsp_id, g);
    obs_sum = rsp_sum;
    obs_id = rsp_id;
    req_valid = 2'b11;
    #1;
    chk("done_rdy", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_vld", rsp_valid, 1);
      chk("hold_sum", rsp_sum, es);
      chk("hold_id", rsp_id, g);
      chk("hold_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("post_vld", rsp_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_sum", rsp_sum, es);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    logic [1:0] v;
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", req_ready, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    last_g = 1'b1;
    @(negedge clk);
    do_op(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, 0, 0);
    chk("t2_sum", obs_sum, 9'h100);
    chk("t2_id", obs_id, 1);
    do_op(2'b01, 8'h5A, 8'h33, 8'h00, 8'h00, 0, 1);
    chk("t1_sum", obs_sum, 9'h08D);
    chk("t1_id", obs_id, 0);
    for (int i = 0; i < 4; i++) do_op(2'b11, rnd(), rnd(), rnd(), rnd(), 0, 1);
    do_op(2'b11, rnd(), rnd(), rnd(), rnd(), 5, 1);
    do_op(2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    chk("t6_zero", obs_sum, 9'h000);
    do_op(2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 1);
    chk("t6_max", obs_sum, 9'h1FE);
    // Abort an operation with reset on its fourth ADD cycle.
    req_valid = 2'b11;
    req0_a = rnd(); req0_b = rnd(); req1_a = rnd(); req1_b = rnd();
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", req_ready, 0);
    chk("abort_vld", rsp_valid, 0);
    chk("abort_sum", rsp_sum, 0);
    chk("abort_id", rsp_id, 0);
    chk("abort_busy", busy, 0);
    last_g = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_norsp", seen, 0);
    do_op(2'b11, rnd(), rnd(), rnd(), rnd(), 0, 0);
    chk("abort_first", obs_id, 0);
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(0, 3));
      do_op(v, rnd(), rnd(), rnd(), rnd(), int'($urandom_range(0, 3)), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
